// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: key FIFO -> calculator command handshake, scan capture into an 8-digit BCD frame.
// Define CALC_SEQ_ZERO_BLANK_EN to blank leading zero digits (4'hF) at frame commit.
module calc_cmd_sequencer #(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [3:0] IDLE_CMD       = 4'hD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [3:0]  calc_cmd,
    input  logic [1:0]  calc_status,
    input  logic [3:0]  calc_data,
    input  logic [3:0]  calc_pos,
    output logic [31:0] disp_digits,
    output logic        disp_valid,
    output logic        seq_busy,
    output logic        seq_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READY, ERROR} state_t;

    state_t        state, state_n;
    logic [3:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] tcnt;
    logic [31:0]   shadow, frame;
    logic [2:0]    scan_idx;
    logic          st_err, st_busy, st_ready, full, empty, timeout;
    logic          push, pop, scan_hit, commit;

    assign st_err   = calc_status == 2'b00;
    assign st_busy  = calc_status == 2'b01;
    assign st_ready = calc_status == 2'b10;
    assign full     = count == (AW+1)'(FIFO_DEPTH);
    assign empty    = count == '0;
    assign timeout  = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign pop      = state == IDLE && !empty && st_ready;
    assign push     = key_valid && key_ready && key_code != IDLE_CMD;
    assign scan_idx = 3'(calc_pos - 4'd1);
    assign scan_hit = state == WAIT_READY && st_busy && calc_pos >= 4'd1 && calc_pos <= 4'd8;
    assign commit   = state == WAIT_READY && state_n == IDLE;

`ifdef CALC_SEQ_ZERO_BLANK_EN
    logic blank;
    always_comb begin
        frame = shadow;
        blank = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            blank = blank && shadow[4*i +: 4] == 4'd0;
            if (blank) frame[4*i +: 4] = 4'hF;
        end
    end
`else
    assign frame = shadow;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = pop ? ISSUE : IDLE;
            ISSUE:      state_n = st_err ? ERROR : st_busy ? WAIT_READY : timeout ? ERROR : ISSUE;
            WAIT_READY: state_n = st_err ? ERROR : st_ready ? IDLE : timeout ? ERROR : WAIT_READY;
            default:    state_n = ERROR;
        endcase
    end

    always_comb begin
        key_ready = !full && state != ERROR && !reset;
        seq_busy  = state == ISSUE || state == WAIT_READY;
        seq_error = state == ERROR;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            calc_cmd    <= IDLE_CMD;
            tcnt        <= '0;
            shadow      <= '0;
            disp_digits <= '0;
            disp_valid  <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            state      <= state_n;
            calc_cmd   <= pop ? fifo[rd_ptr] : state_n == ISSUE ? calc_cmd : IDLE_CMD;
            tcnt       <= (state_n != state || !seq_busy) ? '0 : tcnt + TW'(1);
            disp_valid <= commit;
            if (commit) disp_digits <= frame;
            if (state == ISSUE && state_n == WAIT_READY) shadow <= '0;
            else if (scan_hit) shadow[{scan_idx, 2'b00} +: 4] <= calc_data;
            // Entering or sitting in ERROR discards every queued key.
            if (state_n == ERROR) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo[wr_ptr] <= key_code;
                    wr_ptr       <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed scenarios plus random traffic against a queue-based behavioural model.
module tb_calc_cmd_sequencer;
    localparam logic [3:0] D       = 4'hD;
    localparam int         DEPTH   = 4;
    localparam int         TIMEOUT = 64;
`ifdef CALC_SEQ_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1, key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0, calc_cmd, calc_data = 4'd0, calc_pos = 4'd0;
    logic [1:0]  calc_status = 2'b01;
    logic [31:0] disp_digits;
    logic        key_ready, disp_valid, seq_busy, seq_error;

    int n_checks = 0, n_fail = 0;
    bit cmp_en = 1'b0;

    logic [3:0]  q[$];
    bit          m_err, m_flight, m_scan, m_valid;
    int          m_wait;
    logic [3:0]  m_cmd;
    int          m_frame[8];
    logic [31:0] m_disp;

    calc_cmd_sequencer dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .calc_cmd(calc_cmd), .calc_status(calc_status),
        .calc_data(calc_data), .calc_pos(calc_pos), .disp_digits(disp_digits),
        .disp_valid(disp_valid), .seq_busy(seq_busy), .seq_error(seq_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_frame();
        int msd = 0;
        logic [31:0] r = '0;
        for (int k = 0; k < 8; k++) if (m_frame[k] != 0) msd = k;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = (BLANK && k > msd) ? 4'hF : 4'(m_frame[k]);
        return r;
    endfunction

    task automatic model_step();
        bit ready;
        if (reset) begin
            q.delete();
            m_err = 0; m_flight = 0; m_scan = 0; m_valid = 0; m_wait = 0;
            m_cmd = D; m_disp = '0;
            for (int k = 0; k < 8; k++) m_frame[k] = 0;
            return;
        end
        ready   = q.size() < DEPTH && !m_err;
        m_valid = 0;
        if (!m_err) begin
            if (!m_flight && !m_scan) begin
                if (q.size() > 0 && calc_status == 2'b10) begin
                    m_cmd = q.pop_front(); m_flight = 1; m_wait = 0;
                end
            end else begin
                m_wait++;
                if (calc_status == 2'b00) m_err = 1;
                else if (m_flight && calc_status == 2'b01) begin
                    m_flight = 0; m_scan = 1; m_wait = 0; m_cmd = D;
                    for (int k = 0; k < 8; k++) m_frame[k] = 0;
                end else if (m_scan && calc_status == 2'b10) begin
                    m_disp = pack_frame(); m_valid = 1; m_scan = 0;
                end else begin
                    if (m_scan && calc_status == 2'b01 && calc_pos >= 1 && calc_pos <= 8)
                        m_frame[calc_pos - 1] = int'(calc_data);
                    if (m_wait >= TIMEOUT) m_err = 1;
                end
            end
        end
        if (ready && key_valid && key_code != D) q.push_back(key_code);
        if (m_err) begin
            q.delete(); m_flight = 0; m_scan = 0; m_cmd = D;
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("calc_cmd", 32'(calc_cmd), 32'(m_cmd));
            chk("disp_valid", 32'(disp_valid), 32'(m_valid));
            chk("disp_digits", disp_digits, m_disp);
            chk("seq_busy", 32'(seq_busy), 32'(m_flight || m_scan));
            chk("seq_error", 32'(seq_error), 32'(m_err));
            chk("key_ready", 32'(key_ready), 32'(q.size() < DEPTH && !m_err && !reset));
        end
    end

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic push_key(input logic [3:0] c);
        key_valid = 1'b1; key_code = c;
        cycle();
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic scan(input logic [3:0] d0, input logic [3:0] d1, input int npos);
        calc_status = 2'b01; calc_pos = 4'd0;
        cycle();
        for (int p = 1; p <= npos; p++) begin
            calc_pos  = 4'(p);
            calc_data = p == 1 ? d0 : p == 2 ? d1 : 4'd0;
            cycle();
        end
        calc_pos = 4'd0; calc_status = 2'b10;
        cycle();
    endtask

    task automatic serve(input logic [3:0] code, input logic [3:0] d0, input logic [3:0] d1, input int npos);
        calc_status = 2'b10;
        cycle();
        chk("serve_cmd", 32'(calc_cmd), 32'(code));
        scan(d0, d1, npos);
    endtask

    initial begin
        cycle(); cycle();
        cmp_en = 1'b1;
        chk("rst_cmd", 32'(calc_cmd), 32'hD);
        chk("rst_disp", disp_digits, 32'h0);
        chk("rst_busy", 32'(seq_busy), 32'h0);
        reset = 1'b0;

        calc_status = 2'b10;
        push_key(4'h3);
        cycle();
        chk("t1_cmd", 32'(calc_cmd), 32'h3);
        scan(4'h3, 4'h0, 8);
        chk("t1_valid", 32'(disp_valid), 32'h1);
        chk("t1_frame", disp_digits, BLANK ? 32'hFFFFFFF3 : 32'h00000003);
        chk("t1_idle", 32'(calc_cmd), 32'hD);

        calc_status = 2'b01;
        push_key(4'h1); push_key(4'h2); push_key(4'hA); push_key(4'h4);
        chk("t3_full", 32'(key_ready), 32'h0);
        push_key(4'hE);
        chk("t2_hold", 32'(seq_busy), 32'h0);
        calc_status = 2'b10;
        cycle();
        chk("t3_ready_back", 32'(key_ready), 32'h1);
        chk("t2_first", 32'(calc_cmd), 32'h1);
        scan(4'h1, 4'h0, 1);
        serve(4'h2, 4'h2, 4'h1, 2);
        serve(4'hA, 4'h2, 4'h1, 2);
        serve(4'h4, 4'h4, 4'h0, 1);
        chk("t2_dropped", 32'(seq_busy), 32'h0);
        push_key(4'hE);
        serve(4'hE, 4'h6, 4'h1, 2);
        chk("t2_frame", disp_digits, BLANK ? 32'hFFFFFF16 : 32'h00000016);

        do_reset();
        calc_status = 2'b10;
        push_key(4'h5);
        for (int k = 0; k < 70; k++) cycle();
        chk("t4_error", 32'(seq_error), 32'h1);
        chk("t4_cmd", 32'(calc_cmd), 32'hD);
        chk("t4_ready", 32'(key_ready), 32'h0);
        push_key(4'h7);
        chk("t4_sticky", 32'(seq_error), 32'h1);

        do_reset();
        calc_status = 2'b10;
        push_key(4'h9);
        serve(4'h9, 4'h9, 4'h0, 1);
        push_key(4'h1);
        cycle();
        calc_status = 2'b01; calc_pos = 4'd0;
        cycle();
        for (int p = 1; p <= 3; p++) begin
            calc_pos = 4'(p); calc_data = 4'h7;
            cycle();
        end
        push_key(4'h2);
        calc_status = 2'b00;
        cycle();
        chk("t5_error", 32'(seq_error), 32'h1);
        chk("t5_disp", disp_digits, BLANK ? 32'hFFFFFFF9 : 32'h00000009);
        calc_status = 2'b10;
        cycle();
        chk("t5_flushed", 32'(seq_busy), 32'h0);

        do_reset();
        calc_status = 2'b10;
        push_key(D);
        cycle();
        chk("t6_discard", 32'(seq_busy), 32'h0);
        push_key(4'h7);
        cycle();
        chk("t6_issue", 32'(calc_cmd), 32'h7);
        reset = 1'b1;
        cycle();
        chk("t6_rst_cmd", 32'(calc_cmd), 32'hD);
        chk("t6_rst_busy", 32'(seq_busy), 32'h0);
        reset = 1'b0;
        cycle();
        chk("t6_empty", 32'(seq_busy), 32'h0);

        for (int n = 0; n < 4000; n++) begin
            int r;
            reset     = m_err ? ($urandom_range(7) == 0) : ($urandom_range(499) == 0);
            key_valid = $urandom_range(1) == 1;
            key_code  = 4'($urandom_range(15));
            r = $urandom_range(99);
            calc_status = r < 2 ? 2'b00 : r < 50 ? 2'b01 : 2'b10;
            calc_pos  = 4'($urandom_range(9));
            calc_data = 4'($urandom_range(9));
            cycle();
        end
        reset = 1'b0; key_valid = 1'b0;
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
